// File: rtl/psc_tx_frame_scheduler_if.sv
// TX byte-stream handshake between the frame scheduler and the UART transmitter.
interface psc_tx_frame_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/psc_tx_frame_scheduler.sv
// PSC serial TX frame scheduler: arbitrates trigger / setpoint / readback sources
// and streams fixed 10-byte frames over a valid/ready byte handshake.
// Macro PSC_TX_CRC8_EN: byte 9 is CRC-8 (poly 0x07) over bytes 1..8; otherwise XOR.
//
// state | meaning
// IDLE  | waiting for a source; grants and latches payload
// LOAD  | one cycle to prepare checksum and byte index
// SEND  | presenting frame bytes 0..9 on the handshake
// GAP   | inter-frame quiet time of IDLE_GAP cycles
module psc_tx_frame_scheduler #(
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            trigger_pulse,
  input  logic                            sp_req,
  input  logic [31:0]                     sp_data,
  output logic                            sp_ack,
  input  logic                            rb_req,
  input  logic [7:0]                      rb_addr,
  output logic                            rb_ack,
  psc_tx_frame_scheduler_if.master        tx,
  output logic                            busy,
  output logic [1:0]                      frame_type,
  output logic                            trig_dropped
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  localparam int unsigned GAP_M1   = (IDLE_GAP == 0) ? 0 : IDLE_GAP - 1;
  localparam logic [7:0]  GAP_INIT = GAP_M1[7:0];

  state_t      state_q, state_d;
  logic        trig_pend_q, trig_pend_d;
  logic [15:0] seq_q, seq_d;
  logic        rr_last_q, rr_last_d;
  logic [1:0]  ftype_q, ftype_d;
  logic [31:0] payload_q, payload_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  chk;
  logic        grant_trig, grant_sp, grant_rb, both_req;
`ifdef PSC_TX_CRC8_EN
  logic [7:0]  crc_q, crc_d;
  logic [3:0]  crc_cnt_q, crc_cnt_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`else
  logic [7:0]  chk_q, chk_d;
`endif

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [1:0] ft,
                                            input logic [31:0] pl, input logic [7:0] ck);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SOF_BYTE;
      4'd1:    b = {6'b0, ft};
      4'd2:    b = pl[31:24];
      4'd3:    b = pl[23:16];
      4'd4:    b = pl[15:8];
      4'd5:    b = pl[7:0];
      4'd9:    b = ck;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Arbitration: pending trigger first, then round-robin between setpoint and readback.
  always_comb begin
    both_req   = sp_req && rb_req;
    grant_trig = (state_q == S_IDLE) && trig_pend_q;
    grant_sp   = (state_q == S_IDLE) && !trig_pend_q && sp_req && (!rb_req || rr_last_q);
    grant_rb   = (state_q == S_IDLE) && !trig_pend_q && rb_req && (!sp_req || !rr_last_q);
  end

  // Next-state and datapath for the frame FSM.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    rr_last_d   = rr_last_q;
    ftype_d     = ftype_q;
    payload_d   = payload_q;
    byte_idx_d  = byte_idx_q;
    gap_d       = gap_q;
    trig_pend_d = (trig_pend_q && !grant_trig) || trigger_pulse;
`ifdef PSC_TX_CRC8_EN
    crc_d       = crc_q;
    crc_cnt_d   = crc_cnt_q;
    chk         = crc_q;
`else
    chk_d       = chk_q;
    chk         = chk_q;
`endif

    // seq is bumped while the trigger frame that used it is in LOAD
    if (state_q == S_LOAD && ftype_q == 2'd1) seq_d = seq_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (grant_trig || grant_sp || grant_rb) begin
          state_d    = S_LOAD;
          byte_idx_d = 4'd0;
`ifdef PSC_TX_CRC8_EN
          crc_d      = 8'h00;
          crc_cnt_d  = 4'd1;
`endif
        end
        if (grant_trig) begin
          ftype_d   = 2'd1;
          payload_d = {seq_q, 16'h0000};
        end else if (grant_sp) begin
          ftype_d   = 2'd2;
          payload_d = sp_data;
          if (both_req) rr_last_d = 1'b0;
        end else if (grant_rb) begin
          ftype_d   = 2'd3;
          payload_d = {rb_addr, 24'h000000};
          if (both_req) rr_last_d = 1'b1;
        end
      end
      S_LOAD: begin
        byte_idx_d = 4'd0;
`ifndef PSC_TX_CRC8_EN
        chk_d = {6'b0, ftype_q} ^ payload_q[31:24] ^ payload_q[23:16]
              ^ payload_q[15:8] ^ payload_q[7:0];
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx.tx_ready) begin
          if (byte_idx_q == 4'd9) begin
            if (IDLE_GAP == 0) begin
              state_d = S_IDLE;
              ftype_d = 2'd0;
            end else begin
              state_d = S_GAP;
              gap_d   = GAP_INIT;
            end
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = S_IDLE;
          ftype_d = 2'd0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PSC_TX_CRC8_EN
    // one CRC byte per cycle from LOAD onward; done well before byte 9 is presented
    if ((state_q == S_LOAD || state_q == S_SEND) && crc_cnt_q <= 4'd8) begin
      crc_d     = crc8_step(crc_q, frame_byte(crc_cnt_q, ftype_q, payload_q, 8'h00));
      crc_cnt_d = crc_cnt_q + 4'd1;
    end
`endif
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      trig_pend_q <= 1'b0;
      seq_q       <= 16'h0000;
      rr_last_q   <= 1'b1;
      ftype_q     <= 2'd0;
      payload_q   <= 32'h0;
      byte_idx_q  <= 4'd0;
      gap_q       <= 8'd0;
`ifdef PSC_TX_CRC8_EN
      crc_q       <= 8'h00;
      crc_cnt_q   <= 4'd0;
`else
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      trig_pend_q <= trig_pend_d;
      seq_q       <= seq_d;
      rr_last_q   <= rr_last_d;
      ftype_q     <= ftype_d;
      payload_q   <= payload_d;
      byte_idx_q  <= byte_idx_d;
      gap_q       <= gap_d;
`ifdef PSC_TX_CRC8_EN
      crc_q       <= crc_d;
      crc_cnt_q   <= crc_cnt_d;
`else
      chk_q       <= chk_d;
`endif
    end
  end

  // Output decode; tx_data is a pure function of byte_idx so it holds under backpressure.
  always_comb begin
    tx.tx_valid  = (state_q == S_SEND);
    tx.tx_data   = (state_q == S_SEND) ? frame_byte(byte_idx_q, ftype_q, payload_q, chk) : 8'h00;
    busy         = (state_q != S_IDLE);
    frame_type   = ftype_q;
    sp_ack       = grant_sp;
    rb_ack       = grant_rb;
    trig_dropped = trigger_pulse && trig_pend_q && !grant_trig;
  end

endmodule

// File: tb/tb_psc_tx_frame_scheduler.sv
// Directed bench for psc_tx_frame_scheduler with a byte scoreboard.
module tb_psc_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trigger_pulse = 1'b0;
  logic        sp_req = 1'b0;
  logic [31:0] sp_data = 32'h0;
  logic        sp_ack;
  logic        rb_req = 1'b0;
  logic [7:0]  rb_addr = 8'h0;
  logic        rb_ack;
  logic        busy;
  logic [1:0]  frame_type;
  logic        trig_dropped;

  psc_tx_frame_scheduler_if txi();

  psc_tx_frame_scheduler #(.SOF_BYTE(8'hA5), .IDLE_GAP(4)) dut (
    .clk(clk), .reset(reset), .trigger_pulse(trigger_pulse),
    .sp_req(sp_req), .sp_data(sp_data), .sp_ack(sp_ack),
    .rb_req(rb_req), .rb_addr(rb_addr), .rb_ack(rb_ack),
    .tx(txi), .busy(busy), .frame_type(frame_type), .trig_dropped(trig_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] ft; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int sp_ack_cnt = 0;
  int rb_ack_cnt = 0;
  int drop_cnt = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_data = 8'h0;
  logic       sp_ack_prev = 1'b0;
  logic       rb_ack_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame: XOR or CRC-8 over bytes 1..8; only the first nbytes are queued.
  task automatic push_frame(input logic [1:0] ft, input logic [31:0] pl, input int nbytes);
    logic [7:0]  fb [10];
    logic [63:0] msg;
    logic [7:0]  ck;
    fb[0] = 8'hA5; fb[1] = {6'b0, ft};
    fb[2] = pl[31:24]; fb[3] = pl[23:16]; fb[4] = pl[15:8]; fb[5] = pl[7:0];
    fb[6] = 8'h00; fb[7] = 8'h00; fb[8] = 8'h00;
    msg = {fb[1], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7], fb[8]};
    ck = 8'h00;
`ifdef PSC_TX_CRC8_EN
    for (int i = 63; i >= 0; i--) begin
      logic fbk;
      fbk = ck[7] ^ msg[i];
      ck = {ck[6:0], 1'b0};
      if (fbk) ck = ck ^ 8'h07;
    end
`else
    for (int i = 0; i < 8; i++) ck = ck ^ msg[i*8 +: 8];
`endif
    fb[9] = ck;
    for (int i = 0; i < nbytes; i++) exp_q.push_back('{ft: ft, b: fb[i]});
  endtask

  // Scoreboard pop on each accepted byte, plus hold-stability and ack pulse checks.
  always @(negedge clk) begin
    if (reset) begin
      if (hold_q) begin
        check("hold_valid", {31'b0, txi.tx_valid}, 32'd1);
        check("hold_data", {24'b0, txi.tx_data}, {24'b0, hold_data});
      end
      if (txi.tx_valid && txi.tx_ready) begin
        check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_byte", {24'b0, txi.tx_data}, {24'b0, e.b});
          check("frame_type", {30'b0, frame_type}, {30'b0, e.ft});
        end
        acc_cnt++;
      end
      hold_q    = txi.tx_valid && !txi.tx_ready;
      hold_data = txi.tx_data;
      if (sp_ack) begin
        sp_ack_cnt++;
        check("sp_ack_single", {31'b0, sp_ack_prev}, 32'd0);
        check("sp_ack_req", {31'b0, sp_req}, 32'd1);
      end
      if (rb_ack) begin
        rb_ack_cnt++;
        check("rb_ack_single", {31'b0, rb_ack_prev}, 32'd0);
      end
      if (trig_dropped) drop_cnt++;
    end else begin
      hold_q = 1'b0;
    end
    sp_ack_prev = sp_ack;
    rb_ack_prev = rb_ack;
  end

  // sel: 0 accepted bytes, 1 sp_ack count, 2 rb_ack count
  task automatic wait_cnt(input int sel, input int target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if ((sel == 0 && acc_cnt >= target) || (sel == 1 && sp_ack_cnt >= target) ||
          (sel == 2 && rb_ack_cnt >= target)) begin
        ok = 1;
        break;
      end
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1 trigger_pulse = 1'b1;
    @(posedge clk); #1 trigger_pulse = 1'b0;
  endtask

  initial begin
    int base_acc, base_sp, base_rb;
    txi.tx_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, txi.tx_valid}, 32'd0);
    check("rst_data", {24'b0, txi.tx_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ftype", {30'b0, frame_type}, 32'd0);
    check("rst_drop", {31'b0, trig_dropped}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // single trigger frame, seq 0, then exactly 4 gap cycles
    push_frame(2'd1, 32'h0000_0000, 10);
    pulse_trigger();
    wait_cnt(0, 10, "t1_bytes_timeout");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_gap_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    check("t1_idle_busy", {31'b0, busy}, 32'd0);
    check("t1_idle_ftype", {30'b0, frame_type}, 32'd0);

    // setpoint frame
    push_frame(2'd2, 32'h1234_5678, 10);
    base_sp = sp_ack_cnt;
    @(posedge clk); #1 sp_req = 1'b1; sp_data = 32'h1234_5678;
    wait_cnt(1, base_sp + 1, "t2_ack_timeout");
    #1 sp_req = 1'b0; sp_data = 32'h0;
    wait_idle("t2_idle_timeout");
    check("t2_ack_count", sp_ack_cnt - base_sp, 32'd1);

    // contention: setpoint, readback, setpoint
    base_sp = sp_ack_cnt; base_rb = rb_ack_cnt;
    push_frame(2'd2, 32'hCAFE_F00D, 10);
    push_frame(2'd3, 32'h3C00_0000, 10);
    push_frame(2'd2, 32'hCAFE_F00D, 10);
    @(posedge clk); #1 sp_req = 1'b1; rb_req = 1'b1; sp_data = 32'hCAFE_F00D; rb_addr = 8'h3C;
    wait_cnt(1, base_sp + 2, "t3_ack_timeout");
    #1 sp_req = 1'b0; rb_req = 1'b0;
    wait_idle("t3_idle_timeout");
    check("t3_rb_acks", rb_ack_cnt - base_rb, 32'd1);
    check("t3_sp_acks", sp_ack_cnt - base_sp, 32'd2);

    // trigger during a setpoint frame wins over the still-held setpoint request
    base_sp = sp_ack_cnt; base_acc = acc_cnt;
    push_frame(2'd2, 32'hDEAD_BEEF, 10);
    push_frame(2'd1, 32'h0001_0000, 10);
    push_frame(2'd2, 32'hDEAD_BEEF, 10);
    @(posedge clk); #1 sp_req = 1'b1; sp_data = 32'hDEAD_BEEF;
    wait_cnt(0, base_acc + 3, "t4_send_timeout");
    #1 trigger_pulse = 1'b1;
    @(negedge clk);
    check("t4_drop_first", {31'b0, trig_dropped}, 32'd0);
    @(posedge clk); #1 trigger_pulse = 1'b1;
    @(negedge clk);
    check("t4_drop_second", {31'b0, trig_dropped}, 32'd1);
    @(posedge clk); #1 trigger_pulse = 1'b0;
    @(negedge clk);
    check("t4_drop_after", {31'b0, trig_dropped}, 32'd0);
    wait_cnt(1, base_sp + 2, "t4_ack_timeout");
    #1 sp_req = 1'b0;
    wait_idle("t4_idle_timeout");
    check("t4_drop_count", drop_cnt, 32'd1);

    // random backpressure during a readback frame
    begin
      bit done = 0;
      base_rb = rb_ack_cnt; base_acc = acc_cnt;
      push_frame(2'd3, 32'h8100_0000, 10);
      @(posedge clk); #1 rb_req = 1'b1; rb_addr = 8'h81;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk);
        if (acc_cnt >= base_acc + 10) begin
          done = 1;
          break;
        end
        #1 txi.tx_ready = 1'($urandom_range(0, 1));
        if (rb_ack_cnt > base_rb) rb_req = 1'b0;
      end
      #1 txi.tx_ready = 1'b1; rb_req = 1'b0;
      check("t5_done", {31'b0, done}, 32'd1);
      wait_idle("t5_idle_timeout");
      check("t5_acc_count", acc_cnt - base_acc, 32'd10);
    end

    // reset after byte 4 of a trigger frame (seq 2)
    base_acc = acc_cnt;
    push_frame(2'd1, 32'h0002_0000, 5);
    pulse_trigger();
    wait_cnt(0, base_acc + 5, "t6_bytes_timeout");
    #1 reset = 1'b0;
    #1;
    check("t6_valid_drop", {31'b0, txi.tx_valid}, 32'd0);
    check("t6_busy_drop", {31'b0, busy}, 32'd0);
    check("t6_ftype_drop", {30'b0, frame_type}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    base_acc = acc_cnt;
    repeat (20) @(posedge clk);
    check("t6_no_residual", acc_cnt - base_acc, 32'd0);
    check("t6_sb_empty", exp_q.size(), 32'd0);
    push_frame(2'd1, 32'h0000_0000, 10);
    pulse_trigger();
    wait_idle("t6_idle_timeout");
    check("t6_acc_count", acc_cnt - base_acc, 32'd10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/psc_tx_frame_scheduler.md
Name: psc_tx_frame_scheduler

Overview:
Owns the power-supply-controller serial TX byte stream. It arbitrates between three frame sources: trigger events, setpoint writes and readback requests. It builds fixed 10-byte frames and streams them byte by byte to the UART transmitter over a valid/ready handshake. Trigger frames always win; setpoint and readback share the remaining slots round-robin.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame byte (frame byte 0)
IDLE_GAP, 4, clk cycles of inter-frame gap after the last byte is accepted (0..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
trigger_pulse  in  1  single-cycle trigger event
sp_req  in  1  setpoint request; level, held until sp_ack
sp_data  in  32  setpoint word; sampled in the grant cycle
sp_ack  out  1  one-cycle pulse in the grant cycle for a setpoint frame
rb_req  in  1  readback request; level, held until rb_ack
rb_addr  in  8  readback register address; sampled in the grant cycle
rb_ack  out  1  one-cycle pulse in the grant cycle for a readback frame
tx_data  out  8  current frame byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART can accept the byte
busy  out  1  high in LOAD/SEND/GAP
frame_type  out  2  type of the frame in flight: 0 none, 1 trigger, 2 setpoint, 3 readback
trig_dropped  out  1  one-cycle pulse when a trigger is lost

Behaviour:
- Reset: all outputs 0, state IDLE, trig_pend 0, seq 0, rr_last 1 (so setpoint is served first). Async assertion mid-frame aborts the frame and drops tx_valid immediately; pending trigger and byte index are discarded.
- trig_pend: set by trigger_pulse, cleared on trigger grant. A pulse in the same cycle as a trigger grant leaves trig_pend set (new event).
- trig_dropped: pulses when trigger_pulse arrives while trig_pend=1 and no trigger grant occurs that cycle. trig_pend stays 1.
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE:
  - trig_pend has priority and grants a trigger.
  - Otherwise, if both sp_req and rb_req are high, grant the source not served last (toggle rr_last).
  - Otherwise grant whichever request is high.
  - On any grant: latch the payload, pulse the matching ack, set frame_type, go to LOAD.
- LOAD (1 cycle): byte_idx=0, compute the checksum. Then go to SEND with tx_valid=1.
- SEND:
  - tx_data=byte[byte_idx] and is held stable while tx_valid & !tx_ready.
  - On tx_valid & tx_ready, byte_idx++.
  - Acceptance of byte 9 → tx_valid=0, go to GAP.
- GAP: count IDLE_GAP cycles, then go to IDLE and set frame_type=0. With IDLE_GAP=0, go to IDLE on the next cycle. Requests arriving during LOAD/SEND/GAP wait; they are not granted mid-frame.
- Frame layout:
  - b0=SOF_BYTE
  - b1=type code (0x01 trigger, 0x02 setpoint, 0x03 readback)
  - b2..b5 payload:
    - trigger: seq[15:8], seq[7:0], 0x00, 0x00
    - setpoint: sp_data MSB first
    - readback: rb_addr, 0x00, 0x00, 0x00
  - b6..b8 = 0x00
  - b9 = checksum
- Default checksum: XOR of b1..b8.
- seq: 16-bit; holds the value used by the current trigger frame; increments in the cycle after that frame's grant; wraps 0xFFFF→0x0000.
- Minimum frame period: 1 (grant) + 1 (LOAD) + 10 (bytes) + IDLE_GAP cycles.

Optional Feature:
- Macro: PSC_TX_CRC8_EN.
- Defined: b9 is CRC-8 over b1..b8, polynomial 0x07, init 0x00, no reflection, no final XOR. The CRC is computed bytewise during LOAD/SEND so that b9 is ready when byte_idx=9; timing is unchanged.
- Undefined: b9 is the XOR checksum.

Test Plan:
- Reset, then a single trigger_pulse, tx_ready=1, IDLE_GAP=4 → bytes A5 01 00 00 00 00 00 00 00 01 (XOR); frame_type=1; busy low after 4 gap cycles; seq=1 afterwards.
- sp_req with sp_data=0x12345678 → sp_ack one pulse; bytes A5 02 12 34 56 78 00 00 00 0A.
- sp_req and rb_req both held (rb_addr=0x3C) → setpoint frame, then readback frame (A5 03 3C 00 00 00 00 00 00 3F), then setpoint again.
- trigger_pulse while a setpoint frame is in SEND, plus sp_req still high → trigger frame sent next. A second pulse before that grant → trig_dropped=1 for exactly one cycle.
- tx_ready toggled at random during a frame → tx_data stable whenever valid&!ready; exactly 10 accepted bytes, in order.
- reset asserted after byte 4 of a frame → tx_valid=0 at once; after release, no residual bytes; next trigger frame carries seq 0x0000.
